// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial pattern transmitter.
// Sends a latched PAT_W-bit pattern MSB first, one bit per clock. The pattern
// is repeated a latched number of times, with an optional idle gap between
// repetitions. All outputs are registered, so the first pattern bit appears
// in the cycle right after the accepting edge.
module seq_pattern_tx #(
    parameter int   PAT_W    = 4,
    parameter int   CNT_W    = 8,
    parameter int   GAP_W    = 4,
    parameter logic IDLE_LVL = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [PAT_W-1:0] pat_i,
    input  logic [CNT_W-1:0] rep_i,
    input  logic [GAP_W-1:0] gap_i,
    input  logic             abort,
    output logic             tx,
    output logic             tx_valid,
    output logic             frame,
    output logic             busy,
    output logic             done
);

    localparam int              BW       = $clog2(PAT_W);
    localparam logic [BW-1:0]   BIT_LAST = BW'(PAT_W - 1);
    localparam logic [CNT_W-1:0] REP_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state_reg;
    logic [PAT_W-1:0] pat_reg;   // latched pattern, used to reload each repetition
    logic [PAT_W-1:0] sh_reg;    // bits still to be sent in this repetition, MSB next
    logic [BW-1:0]    bit_reg;   // index of the pattern bit currently on tx
    logic [CNT_W-1:0] rep_reg;   // repetitions left, including the one in flight
    logic [GAP_W-1:0] gap_reg;   // latched gap length
    logic [GAP_W-1:0] gcnt_reg;  // gap cycles left after the current one

    // Transmitter FSM with registered outputs; abort overrides every state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
            pat_reg   <= '0;
            sh_reg    <= '0;
            bit_reg   <= '0;
            rep_reg   <= '0;
            gap_reg   <= '0;
            gcnt_reg  <= '0;
            tx        <= IDLE_LVL;
            tx_valid  <= 1'b0;
            frame     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (abort) begin
            state_reg <= IDLE;
            tx        <= IDLE_LVL;
            tx_valid  <= 1'b0;
            frame     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    tx       <= IDLE_LVL;
                    tx_valid <= 1'b0;
                    frame    <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    // A zero repeat count is a no-op request and is dropped.
                    if (start && (rep_i != '0)) begin
                        pat_reg   <= pat_i;
                        gap_reg   <= gap_i;
                        rep_reg   <= rep_i;
                        sh_reg    <= pat_i << 1;
                        bit_reg   <= BIT_LAST;
                        tx        <= pat_i[PAT_W-1];
                        tx_valid  <= 1'b1;
                        frame     <= 1'b1;
                        busy      <= 1'b1;
                        state_reg <= SHIFT;
                    end
                end

                SHIFT: begin
                    done <= 1'b0;
                    if (bit_reg != '0) begin
                        tx      <= sh_reg[PAT_W-1];
                        sh_reg  <= sh_reg << 1;
                        bit_reg <= bit_reg - 1'b1;
                        frame   <= 1'b0;
                    end else if (rep_reg == REP_ONE) begin
                        // Last bit of the last repetition has just been sent.
                        state_reg <= IDLE;
                        tx        <= IDLE_LVL;
                        tx_valid  <= 1'b0;
                        frame     <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        rep_reg <= rep_reg - 1'b1;
                        if (gap_reg == '0) begin
                            // Back-to-back repetition: reload without a gap.
                            tx      <= pat_reg[PAT_W-1];
                            sh_reg  <= pat_reg << 1;
                            bit_reg <= BIT_LAST;
                            frame   <= 1'b1;
                        end else begin
                            state_reg <= GAP;
                            gcnt_reg  <= gap_reg - 1'b1;
                            tx        <= IDLE_LVL;
                            tx_valid  <= 1'b0;
                            frame     <= 1'b0;
                        end
                    end
                end

                GAP: begin
                    done <= 1'b0;
                    if (gcnt_reg == '0) begin
                        state_reg <= SHIFT;
                        tx        <= pat_reg[PAT_W-1];
                        sh_reg    <= pat_reg << 1;
                        bit_reg   <= BIT_LAST;
                        tx_valid  <= 1'b1;
                        frame     <= 1'b1;
                    end else begin
                        gcnt_reg <= gcnt_reg - 1'b1;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    tx        <= IDLE_LVL;
                    tx_valid  <= 1'b0;
                    frame     <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Testbench for seq_pattern_tx: per-cycle comparison against a waveform
// queue built from the transmission rules, plus hand-computed expectations.
module tb_seq_pattern_tx;

    localparam int PAT_W = 4;
    localparam int CNT_W = 8;
    localparam int GAP_W = 4;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             start = 1'b0;
    logic [PAT_W-1:0] pat_i = '0;
    logic [CNT_W-1:0] rep_i = '0;
    logic [GAP_W-1:0] gap_i = '0;
    logic             abort = 1'b0;
    logic             tx, tx_valid, frame, busy, done;

    seq_pattern_tx #(
        .PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W), .IDLE_LVL(1'b1)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .pat_i(pat_i), .rep_i(rep_i),
        .gap_i(gap_i), .abort(abort), .tx(tx), .tx_valid(tx_valid),
        .frame(frame), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Expected output vector per cycle: {tx, tx_valid, frame, busy, done}.
    localparam logic [4:0] IDLE_E = 5'b10000;
    logic [4:0] cur = IDLE_E;
    logic [4:0] q[$];

    // Model: on an accepted start, write out the whole expected waveform.
    always @(posedge clk) begin
        if (rstn) begin
            if (abort) begin
                q.delete();
                cur = IDLE_E;
            end else begin
                if (!cur[1] && start && (rep_i != 0)) begin
                    q.delete();
                    for (int r = 0; r < int'(rep_i); r++) begin
                        for (int b = PAT_W - 1; b >= 0; b--)
                            q.push_back({pat_i[b], 1'b1, (b == PAT_W - 1), 1'b1, 1'b0});
                        if (r < int'(rep_i) - 1)
                            for (int g = 0; g < int'(gap_i); g++)
                                q.push_back(5'b10010);
                    end
                    q.push_back(5'b10001);
                end
                cur = (q.size() > 0) ? q.pop_front() : IDLE_E;
            end
        end
    end

    // Reset discards everything the model had scheduled.
    always @(negedge rstn) begin
        q.delete();
        cur = IDLE_E;
    end

    int busy_cnt, valid_cnt, frame_cnt, done_cnt, det_cnt;
    logic [3:0] win = 4'b1111;

    // Compare process plus activity counters and a 0110 detector on tx.
    always @(negedge clk) begin
        chk("outputs", {27'b0, tx, tx_valid, frame, busy, done}, {27'b0, cur});
        busy_cnt  += int'(busy);
        valid_cnt += int'(tx_valid);
        frame_cnt += int'(frame);
        done_cnt  += int'(done);
        win = {win[2:0], tx};
        if (win == 4'b0110) det_cnt++;
    end

    task automatic clr();
        busy_cnt = 0; valid_cnt = 0; frame_cnt = 0; done_cnt = 0; det_cnt = 0;
    endtask

    // Presents one start cycle; returns in the cycle showing the first bit.
    task automatic send(input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] r,
                        input logic [GAP_W-1:0] g);
        @(negedge clk);
        clr();
        pat_i = p; rep_i = r; gap_i = g; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pat_i = ~p; rep_i = 8'd7; gap_i = 4'd5;
    endtask

    logic [3:0] exp_bits;

    initial begin
        repeat (3) @(negedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
        chk("reset_tx", tx, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);

        // 1: single pattern 0110
        exp_bits = 4'b0110;
        send(4'b0110, 8'd1, 4'd0);
        for (int k = 0; k < 4; k++) begin
            chk("t1_tx", tx, exp_bits[3 - k]);
            chk("t1_frame", frame, (k == 0));
            @(negedge clk);
        end
        chk("t1_done", done, 1'b1);
        chk("t1_done_busy", busy, 1'b0);
        @(negedge clk);
        chk("t1_done_once", done, 1'b0);
        repeat (3) @(negedge clk);
        chk("t1_detect", det_cnt, 1);

        // 2: repeats with gap
        send(4'b1011, 8'd3, 4'd2);
        repeat (20) @(negedge clk);
        chk("t2_busy", busy_cnt, 16);
        chk("t2_valid", valid_cnt, 12);
        chk("t2_frame", frame_cnt, 3);
        chk("t2_done", done_cnt, 1);

        // 3: back-to-back repeats, ignored start while busy
        send(4'b1100, 8'd2, 4'd0);
        repeat (3) @(negedge clk);
        pat_i = 4'b1111; rep_i = 8'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("t3_valid", valid_cnt, 8);
        chk("t3_busy", busy_cnt, 8);
        chk("t3_frame", frame_cnt, 2);
        chk("t3_done", done_cnt, 1);

        // 4: zero repeat count, then a normal start
        send(4'b0101, 8'd0, 4'd3);
        repeat (5) @(negedge clk);
        chk("t4_busy", busy_cnt, 0);
        chk("t4_done", done_cnt, 0);
        send(4'b0101, 8'd1, 4'd0);
        repeat (6) @(negedge clk);
        chk("t4_valid", valid_cnt, 4);
        chk("t4_done2", done_cnt, 1);

        // 5: abort on the third bit, then abort together with start
        send(4'b1101, 8'd1, 4'd0);
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t5_tx", tx, 1'b1);
        chk("t5_busy", busy, 1'b0);
        repeat (5) @(negedge clk);
        chk("t5_done", done_cnt, 0);
        chk("t5_valid", valid_cnt, 3);
        clr();
        pat_i = 4'b0000; rep_i = 8'd1; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        repeat (6) @(negedge clk);
        chk("t5_both_valid", valid_cnt, 0);
        chk("t5_both_busy", busy_cnt, 0);

        // 6: asynchronous reset in the middle of a gap
        send(4'b1001, 8'd3, 4'd4);
        repeat (4) @(negedge clk);
        chk("t6_in_gap", {tx_valid, busy}, 2'b01);
        #3 rstn = 1'b0;
        #1;
        chk("t6_rst_tx", tx, 1'b1);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_valid", tx_valid, 1'b0);
        @(negedge clk);
        #2 rstn = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_idle", busy, 1'b0);
        send(4'b1001, 8'd1, 4'd0);
        repeat (6) @(negedge clk);
        chk("t6_valid", valid_cnt, 4);
        chk("t6_done", done_cnt, 1);
        chk("t6_frame", frame_cnt, 1);

        // 7: maximum repeat count, no wrap
        send(4'b1001, 8'd255, 4'd0);
        repeat (1030) @(negedge clk);
        chk("t7_busy", busy_cnt, 1020);
        chk("t7_frame", frame_cnt, 255);
        chk("t7_done", done_cnt, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
